// File: rtl/alu_result_uart_tx.sv
// alu_result_uart_tx: captures {op, result} pairs from the ALU into a small FIFO
// and serialises each entry as two 8N1 UART frames: header {HDR_TAG, op}, then result.
module alu_result_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [4:0]  HDR_TAG      = 5'b10100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] res_in,
    input  logic [2:0] op_in,
    input  logic       res_valid,
    input  logic       clr_ovf,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int unsigned PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW       = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [15:0]   BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // FIFO storage and control
    logic [10:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          fifo_full_q, overflow_q, overflow_d;
    logic          push, pop, drop;
    logic [10:0]   head;

    // Serialiser state
    state_t        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic          byte_sel_q, byte_sel_d;
    logic          load_res;
    logic [7:0]    shift_q, hold_q;

    assign head = mem_q[rd_ptr_q];

    // FIFO push/pop decisions; a strobe into a full FIFO is accepted only if the head leaves this cycle
    always_comb begin
        pop        = (state_q == IDLE) && (count_q != '0);
        push       = res_valid && ((count_q != DEPTH_C) || pop);
        drop       = res_valid && !push;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // FIFO pointers, occupancy, full and sticky overflow flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fifo_full_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q     <= count_d;
            fifo_full_q <= (count_d == DEPTH_C);
            overflow_q  <= overflow_d;
        end
    end

    // FIFO storage write; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {op_in, res_in};
    end

    // Serialiser next-state: baud counter restarts on every state or bit change
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + 16'd1;
        bit_d      = bit_q;
        byte_sel_d = byte_sel_q;
        load_res   = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (count_q != '0) begin
                    state_d    = START;
                    byte_sel_d = 1'b0;
                end
            end
            START: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d = '0;
                    if (!byte_sel_q) begin
                        load_res   = 1'b1;
                        byte_sel_d = 1'b1;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Serialiser control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_sel_q <= byte_sel_d;
        end
    end

    // Byte shift/hold registers: header loaded on pop, result byte swapped in after the first stop bit
    always_ff @(posedge clk) begin
        if (pop) begin
            shift_q <= {HDR_TAG, head[10:8]};
            hold_q  <= head[7:0];
        end else if (load_res) begin
            shift_q <= hold_q;
        end
    end

    // Line driver decoded from registered state so reset forces the line high at once
    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[bit_q];
            default: tx = 1'b1;
        endcase
    end

    assign busy      = (state_q != IDLE) || (count_q != '0);
    assign fifo_full = fifo_full_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Testbench for alu_result_uart_tx: scoreboard of expected UART bytes, one task per scenario.
module tb_alu_result_uart_tx;

    localparam int CPB  = 4;
    localparam int DEP  = 4;
    localparam int PAIR = 20 * CPB;
    localparam logic [4:0] TAG = 5'b10100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] res_in = 8'h00;
    logic [2:0] op_in = 3'd0;
    logic       res_valid = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       tx, busy, fifo_full, overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int         start_cyc[$];

    alu_result_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEP),
        .HDR_TAG(TAG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .res_in(res_in),
        .op_in(op_in),
        .res_valid(res_valid),
        .clr_ovf(clr_ovf),
        .tx(tx),
        .busy(busy),
        .fifo_full(fifo_full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    // Drive one strobe (called just after a rising edge); accepted entries go to the scoreboard
    task automatic strobe(input logic [7:0] r, input logic [2:0] op, input bit accepted);
        res_in    = r;
        op_in     = op;
        res_valid = 1'b1;
        if (accepted) begin
            exp_q.push_back({TAG, op});
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        res_valid = 1'b0;
    endtask

    // Receive one 8N1 frame, sampling mid-bit on falling edges
    task automatic rx_byte(output logic [7:0] b, output bit ok);
        int w;
        ok = 1'b0;
        b  = 8'h00;
        w  = 0;
        @(negedge clk);
        while (tx !== 1'b0 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        if (tx !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_timeout: tx=%b, required a start bit within 4000 cycles", tx);
            return;
        end
        start_cyc.push_back(cyc);
        repeat (CPB / 2) @(negedge clk);
        n_checks++;
        if (tx !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_start_bit: tx=%b, required 0", tx);
        end
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        n_checks++;
        if (tx !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_stop_bit: tx=%b, required 1", tx);
        end
        ok = 1'b1;
    endtask

    // Receive n frames and compare each against the scoreboard head
    task automatic rx_check(input int n);
        logic [7:0] b, e;
        bit ok;
        for (int i = 0; i < n; i++) begin
            rx_byte(b, ok);
            if (!ok) return;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rx_extra_byte: got %h, required no byte", b);
            end else begin
                e = exp_q.pop_front();
                if (b !== e) begin
                    n_fail++;
                    $display("FAIL rx_byte[%0d]: got %h, required %h", i, b, e);
                end
            end
        end
    endtask

    task automatic wait_idle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b, required 1", tx); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++;
        if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b, required 0", fifo_full); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", overflow); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [7:0] by [2];
        logic e;
        bit bit_ok;
        int p;
        strobe(8'h5A, 3'd2, 1'b1);
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_pop_cycle: tx=%b busy=%b, required tx=1 busy=1", tx, busy);
        end
        by[0] = exp_q.pop_front();
        by[1] = exp_q.pop_front();
        bit_ok = 1'b1;
        for (int k = 0; k < 2 * PAIR / 2; k++) begin
            @(negedge clk);
            p = (k % 40) / CPB;
            if (p == 0)      e = 1'b0;
            else if (p == 9) e = 1'b1;
            else             e = by[k / 40][p - 1];
            if (tx !== e || busy !== 1'b1) bit_ok = 1'b0;
            if (k % CPB == CPB - 1) begin
                n_checks++;
                if (!bit_ok) begin
                    n_fail++;
                    $display("FAIL basic_bit[%0d]: tx=%b busy=%b, required tx=%b busy=1", k / CPB, tx, busy, e);
                end
                bit_ok = 1'b1;
            end
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_end: busy=%b tx=%b, required busy=0 tx=1", busy, tx);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        start_cyc.delete();
        fork
            begin
                strobe(8'h01, 3'd0, 1'b1);
                strobe(8'hFF, 3'd1, 1'b1);
                strobe(8'h80, 3'd5, 1'b1);
            end
            rx_check(6);
        join
        n_checks++;
        if (start_cyc.size() != 6) begin
            n_fail++;
            $display("FAIL b2b_frames: got %0d frames, required 6", start_cyc.size());
        end else begin
            if (start_cyc[1] - start_cyc[0] != 40 || start_cyc[2] - start_cyc[0] != 81 ||
                start_cyc[4] - start_cyc[2] != 81) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d/%0d/%0d, required 40/81/81",
                         start_cyc[1] - start_cyc[0], start_cyc[2] - start_cyc[0],
                         start_cyc[4] - start_cyc[2]);
            end
        end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b, required 0", overflow); end
        wait_idle();
    endtask

    task automatic test_overflow();
        bit quiet;
        fork
            begin
                for (int i = 0; i < 6; i++) strobe(8'h10 + 8'(i), 3'(i), i < 5);
                @(negedge clk);
                n_checks++;
                if (fifo_full !== 1'b1 || overflow !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ovf_flags: full=%b ovf=%b, required 1/1", fifo_full, overflow);
                end
            end
            rx_check(10);
        join
        quiet = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_extra_pair: quiet=%b busy=%b, required quiet=1 busy=0", quiet, busy);
        end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
        @(posedge clk);
        #1;
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        @(negedge clk);
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b, required 0", overflow); end
        wait_idle();
    endtask

    task automatic test_full_pushpop();
        fork
            begin
                for (int i = 0; i < 5; i++) strobe(8'h20 + 8'(i), 3'(i + 3), 1'b1);
                repeat (PAIR + 1 - 4) @(posedge clk);
                #1;
                strobe(8'h99, 3'd1, 1'b1);
                @(negedge clk);
                n_checks++;
                if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fullpp_flags: full=%b ovf=%b, required 1/0", fifo_full, overflow);
                end
            end
            rx_check(12);
        join
        wait_idle();
    endtask

    task automatic test_reset_midframe();
        strobe(8'h34, 3'd4, 1'b0);
        strobe(8'hC3, 3'd6, 1'b0);
        @(negedge clk);
        repeat (57) @(negedge clk);
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL rstmid_bit3: got %b, required 0", tx); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_full !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_abort: tx=%b busy=%b full=%b, required 1/0/0", tx, busy, fifo_full);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_empty: tx=%b busy=%b, required 1/0", tx, busy);
        end
        @(posedge clk);
        #1;
        fork
            strobe(8'h81, 3'd7, 1'b1);
            rx_check(2);
        join
        wait_idle();
    endtask

    task automatic test_clr_with_drop();
        fork
            begin
                for (int i = 0; i < 5; i++) strobe(8'h40 + 8'(i), 3'(7 - i), 1'b1);
                strobe(8'hEE, 3'd0, 1'b0);
                res_in    = 8'hDD;
                op_in     = 3'd3;
                res_valid = 1'b1;
                clr_ovf   = 1'b1;
                @(posedge clk);
                #1;
                res_valid = 1'b0;
                clr_ovf   = 1'b0;
                @(negedge clk);
                n_checks++;
                if (overflow !== 1'b1) begin n_fail++; $display("FAIL clrdrop_setwins: got %b, required 1", overflow); end
                clr_ovf = 1'b1;
                @(posedge clk);
                #1;
                clr_ovf = 1'b0;
                @(negedge clk);
                n_checks++;
                if (overflow !== 1'b0) begin n_fail++; $display("FAIL clrdrop_clear: got %b, required 0", overflow); end
            end
            rx_check(10);
        join
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_full_pushpop();
        test_reset_midframe();
        test_clr_with_drop();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d bytes pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_uart_tx.md
Name: alu_result_uart_tx

Overview:
Downstream stage of the ALU. It captures each ALU result together with its operation code on a one-cycle strobe and buffers it in a small FIFO. It then serialises each entry as two 8N1 UART frames: a header byte carrying the op code, then the result byte. This gives the board a host-readable log of the ALU's 1-second operation cycle.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
FIFO_DEPTH, 4, number of buffered result entries; power of two, 2..16.
HDR_TAG, 5'b10100, upper 5 bits of the header byte.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
res_in  input  8  ALU result R.
op_in  input  3  ALU operation selector associated with res_in.
res_valid  input  1  one-cycle strobe; res_in/op_in sampled on this edge.
clr_ovf  input  1  synchronous clear of the overflow flag.
tx  output  1  UART serial line; idle high.
busy  output  1  high while a frame pair is in flight or the FIFO is non-empty.
fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
overflow  output  1  sticky; set when a strobe is dropped.

Behaviour:
- Reset (async, rst=1): tx=1, busy=0, fifo_full=0, overflow=0. FIFO pointers and count go to 0. FSM goes to IDLE. Bit and baud counters go to 0. Reset mid-frame aborts the frame immediately; tx returns high in the same cycle rst asserts.
- FIFO entry is 11 bits: {op_in, res_in}. A push occurs on res_valid when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs in the same cycle. In the second case count is unchanged and no overflow is flagged.
- Full with no pop: res_valid is dropped, FIFO contents are unchanged, and overflow<=1.
- clr_ovf=1 clears overflow next cycle. If a drop happens in the same cycle as clr_ovf, set wins.
- Pointers wrap modulo FIFO_DEPTH.
- fifo_full is count==FIFO_DEPTH and is registered (reflects the post-update count).
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register and go to START. Pop happens in the IDLE cycle. The first byte loaded is the header {HDR_TAG, op}; byte_sel=0.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift[bit_idx], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end of STOP:
    - if byte_sel=0: load the held result byte, set byte_sel=1, go to START directly (no IDLE gap);
    - if byte_sel=1: go to IDLE.
- Frame pair length is 20*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the second stop bit. Between pairs there is at least one IDLE cycle.
- The baud counter counts 0..CLKS_PER_BIT-1 and resets on every state or bit change. There is no fractional baud.
- busy = (state!=IDLE) | (count!=0), combinational from registers.
- Latency: with an empty FIFO and IDLE, a strobe at cycle N gives push at N, pop at N+1, and tx falls at N+2.
- Op and result are transmitted exactly as captured; no width changes. Op values 6 and 7 are transmitted unmodified.
- Inputs are assumed synchronous to clk; no internal synchroniser.

Test Plan:
1. Basic frame (CLKS_PER_BIT=4): reset, then strobe res_in=0x5A, op_in=3'd2 -> tx falls 2 cycles later. Header 0xA2 is sent LSB first (0,1,0,0,0,1,0,1), stop, then 0x5A, stop. Each bit is 4 cycles and the total is 80 cycles. busy is high throughout and drops after the second stop.
2. Back-to-back entries: 3 strobes (0x01/op0, 0xFF/op1, 0x80/op5) on consecutive cycles -> three frame pairs are sent in order. Headers are 0xA0, 0xA1, 0xA5. Exactly 1 IDLE cycle separates pairs. overflow stays 0.
3. Overflow: 6 strobes while the first pair is in flight. The 1st is popped, entries 2–5 fill the FIFO, and the 6th is dropped -> fifo_full=1, overflow=1. Exactly 5 pairs are transmitted. clr_ovf then clears overflow.
4. Push and pop together while full: hold the FIFO full and strobe in the IDLE pop cycle -> entry accepted, count stays at 4, overflow stays 0.
5. Reset mid-frame: assert rst during DATA bit 3 of the result byte -> tx=1 immediately and busy=0. The FIFO is empty after release, and a new strobe transmits correctly.
6. clr_ovf together with a drop in the same cycle -> overflow remains 1.
